// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: controller op codes, register indices, bit positions, FSM states.
package cp0_unit_pkg;

    localparam logic [1:0] EXE_CP_NONE  = 2'b00;
    localparam logic [1:0] EXE_CP_STORE = 2'b01;
    localparam logic [1:0] EXE_CP0_ERET = 2'b10;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_REG_EPC     = 5'd14;
    localparam logic [4:0] CP0_REG_EHBR    = 5'd15;

    localparam int BIT_IE  = 0;
    localparam int BIT_IP0 = 8;
    localparam int BIT_IPT = 15;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_HANDLER = 1'b1
    } cp0_state_e;

endpackage

// File: rtl/cp0_unit_irq_sync.sv
// cp0_irq_sync: two-flop synchronizer for the async interrupt level, followed by a
// rising-edge detector producing a single-cycle pulse in the clk domain.
module cp0_irq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_i,
    output logic edge_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= irq_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign edge_o = sync_q & ~prev_q;

endmodule

// File: rtl/cp0_unit.sv
// CP0: STATUS/CAUSE/EPC/EHBR, interrupt entry and ERET redirect. Optional Count/Compare
// timer interrupt is built when CP0_TIMER_EN is defined.
//   state      | meaning
//   ST_IDLE    | normal execution, interrupts may be taken
//   ST_HANDLER | inside handler, waiting for ERET
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] EHBR_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  oper,
    input  logic [4:0]  addr_r,
    output logic [31:0] data_r,
    input  logic [4:0]  addr_w,
    input  logic [31:0] data_w,
    input  logic [31:0] ret_addr,
    input  logic        ret_valid,
    input  logic        ir_in,
    output logic        jump_en,
    output logic [31:0] jump_addr,
    output logic        in_handler
);

    cp0_state_e  state_q, state_d;
    logic        ie_q, ie_d;
    logic        pend_q, pend_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] ehbr_q, ehbr_d;
    logic        jump_en_q, jump_en_d;
    logic [31:0] jump_addr_q, jump_addr_d;

    logic        ir_edge;
    logic        tpend;
    logic        is_store;
    logic        is_eret;
    logic        take;
    logic [31:0] cause;

    cp0_irq_sync u_irq_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .irq_i  (ir_in),
        .edge_o (ir_edge)
    );

    assign is_store = en && (oper == EXE_CP_STORE);
    assign is_eret  = en && (oper == EXE_CP0_ERET);
    assign take     = (pend_q | tpend) & ie_q & ret_valid & en
                    & (state_q == ST_IDLE) & (oper != EXE_CP0_ERET);

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tpend_q, tpend_d;

    always_comb begin
        count_d   = count_q + {31'b0, en};
        compare_d = compare_q;
        tpend_d   = tpend_q | (en && (count_q == compare_q));
        if (is_store && addr_w == CP0_REG_COUNT) begin
            count_d = data_w;
        end
        if (is_store && addr_w == CP0_REG_COMPARE) begin
            compare_d = data_w;
            tpend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= 32'h0;
            compare_q <= 32'h0;
            tpend_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tpend_q   <= tpend_d;
        end
    end

    assign tpend = tpend_q;
`else
    assign tpend = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ie_d        = ie_q;
        epc_d       = epc_q;
        ehbr_d      = ehbr_q;
        jump_en_d   = 1'b0;
        jump_addr_d = jump_addr_q;

        if (is_store) begin
            case (addr_w)
                CP0_REG_STATUS: ie_d   = data_w[BIT_IE];
                CP0_REG_EPC:    epc_d  = data_w;
                CP0_REG_EHBR:   ehbr_d = data_w;
                default: ;
            endcase
        end

        // ERET wins over a take; a take overrides any same-cycle MTC0 to IE/EPC.
        if (is_eret) begin
            ie_d        = 1'b1;
            state_d     = ST_IDLE;
            jump_en_d   = 1'b1;
            jump_addr_d = epc_q;
        end else if (take) begin
            ie_d        = 1'b0;
            epc_d       = ret_addr;
            state_d     = ST_HANDLER;
            jump_en_d   = 1'b1;
            jump_addr_d = ehbr_q;
        end

        pend_d = (pend_q & ~take) | ir_edge;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ie_q        <= 1'b0;
            pend_q      <= 1'b0;
            epc_q       <= 32'h0;
            ehbr_q      <= EHBR_RESET;
            jump_en_q   <= 1'b0;
            jump_addr_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            ie_q        <= ie_d;
            pend_q      <= pend_d;
            epc_q       <= epc_d;
            ehbr_q      <= ehbr_d;
            jump_en_q   <= jump_en_d;
            jump_addr_q <= jump_addr_d;
        end
    end

    always_comb begin
        cause          = 32'h0;
        cause[BIT_IP0] = pend_q;
        cause[BIT_IPT] = tpend;
    end

    always_comb begin
        data_r = 32'h0;
        case (addr_r)
            CP0_REG_STATUS: data_r = {31'b0, ie_q};
            CP0_REG_CAUSE:  data_r = cause;
            CP0_REG_EPC:    data_r = epc_q;
            CP0_REG_EHBR:   data_r = ehbr_q;
`ifdef CP0_TIMER_EN
            CP0_REG_COUNT:   data_r = count_q;
            CP0_REG_COMPARE: data_r = compare_q;
`endif
            default: ;
        endcase
    end

    assign jump_en    = jump_en_q;
    assign jump_addr  = jump_addr_q;
    assign in_handler = (state_q == ST_HANDLER);

endmodule
